// File: rtl/reset_release_sequencer_if.sv
// Handshake bundle between the reset release sequencer and its downstream domains.
// The sequencer uses the master view; the domains (or a bench) use the slave view.
interface reset_release_sequencer_if #(
  parameter int unsigned DOMAIN_NUM = 4
) ();

  localparam int unsigned ErrW = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1;

  logic                  soft_rst_req;
  logic [DOMAIN_NUM-1:0] init_done;
  logic [DOMAIN_NUM-1:0] domain_rstn;
  logic                  all_ready;
  logic                  seq_busy;
  logic                  timeout_err;
  logic [ErrW-1:0]       err_domain;

  modport master (
    input  soft_rst_req,
    input  init_done,
    output domain_rstn,
    output all_ready,
    output seq_busy,
    output timeout_err,
    output err_domain
  );

  modport slave (
    output soft_rst_req,
    output init_done,
    input  domain_rstn,
    input  all_ready,
    input  seq_busy,
    input  timeout_err,
    input  err_domain
  );

endinterface

// File: rtl/reset_release_sequencer.sv
// Releases downstream reset domains one at a time, waiting for each domain's init_done
// acknowledge before moving on; a missing acknowledge parks all domains in reset.
module reset_release_sequencer #(
  parameter int unsigned DOMAIN_NUM  = 4,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input logic                          sys_clk,
  input logic                          rst,
  reset_release_sequencer_if.master    bus
);

  localparam int unsigned KW   = (DOMAIN_NUM > 1) ? $clog2(DOMAIN_NUM) : 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(ACK_TIMEOUT - 1);
  localparam logic [KW-1:0]   KLast   = KW'(DOMAIN_NUM - 1);

  typedef enum logic [2:0] {
    StHold,
    StRelease,
    StWaitAck,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [ToW-1:0]        to_q, to_d;
  logic [DOMAIN_NUM-1:0] rstn_q, rstn_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  terr_q, terr_d;
  logic [KW-1:0]         edom_q, edom_d;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StHold;
      k_q     <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      terr_q  <= 1'b0;
      edom_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      edom_q  <= edom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    to_d    = to_q;
    rstn_d  = rstn_q;
    terr_d  = terr_q;
    edom_d  = edom_q;

    if (bus.soft_rst_req) begin
      // Restart wins over any acknowledge or timeout seen in the same cycle.
      state_d = StHold;
      k_d     = '0;
      gap_d   = '0;
      to_d    = '0;
      rstn_d  = '0;
      terr_d  = 1'b0;
      edom_d  = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (gap_q == GapLast) begin
            gap_d   = '0;
            state_d = StRelease;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
        StRelease: begin
          rstn_d[k_q] = 1'b1;
          to_d        = '0;
          state_d     = StWaitAck;
        end
        StWaitAck: begin
          if (bus.init_done[k_q]) begin
            to_d = '0;
            if (k_q == KLast) begin
              state_d = StDone;
            end else begin
              k_d     = k_q + KW'(1);
              gap_d   = '0;
              state_d = StHold;
            end
          end else if (to_q == ToLast) begin
            state_d = StError;
            rstn_d  = '0;
            terr_d  = 1'b1;
            edom_d  = k_q;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
        StDone, StError: begin
          state_d = state_q;
        end
        default: begin
          state_d = StHold;
        end
      endcase
    end

    // Status flags follow the state being entered so they change on the same edge.
    ready_d = (state_d == StDone);
    busy_d  = (state_d != StDone) && (state_d != StError);
  end

  assign bus.domain_rstn = rstn_q;
  assign bus.all_ready   = ready_q;
  assign bus.seq_busy    = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.err_domain  = edom_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Scoreboard bench: each task schedules input changes at fixed edges and queues the
// output transitions they should cause; a negedge monitor pops and compares them.
module tb_reset_release_sequencer;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  reset_release_sequencer_if #(.DOMAIN_NUM(4)) bus ();

  reset_release_sequencer #(
    .DOMAIN_NUM (4),
    .GAP_CYCLES (8),
    .ACK_TIMEOUT(256)
  ) dut (
    .sys_clk(sys_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         edge_no;
    logic [3:0] rstn;
    logic       ready;
    logic       busy;
    logic       terr;
    logic [1:0] edom;
  } ev_t;

  int  edge_cnt = 0;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  ev_t exp_q[$];
  ev_t prev;

  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  // Any change on the outputs must match the next queued transition, including its edge.
  always @(negedge sys_clk) begin
    ev_t cur;
    ev_t e;
    cur.edge_no = edge_cnt;
    cur.rstn    = bus.domain_rstn;
    cur.ready   = bus.all_ready;
    cur.busy    = bus.seq_busy;
    cur.terr    = bus.timeout_err;
    cur.edom    = bus.err_domain;
    if (mon_en && (cur.rstn !== prev.rstn || cur.ready !== prev.ready ||
                   cur.busy !== prev.busy || cur.terr !== prev.terr || cur.edom !== prev.edom))
    begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change edge=%0d rstn=%b ready=%b busy=%b terr=%b edom=%0d",
                 cur.edge_no, cur.rstn, cur.ready, cur.busy, cur.terr, cur.edom);
      end else begin
        e = exp_q.pop_front();
        if (e.edge_no != cur.edge_no || e.rstn !== cur.rstn || e.ready !== cur.ready ||
            e.busy !== cur.busy || e.terr !== cur.terr || e.edom !== cur.edom) begin
          n_fail++;
          $display("FAIL transition got edge=%0d rstn=%b ready=%b busy=%b terr=%b edom=%0d, want edge=%0d rstn=%b ready=%b busy=%b terr=%b edom=%0d",
                   cur.edge_no, cur.rstn, cur.ready, cur.busy, cur.terr, cur.edom,
                   e.edge_no, e.rstn, e.ready, e.busy, e.terr, e.edom);
        end
      end
    end
    prev = cur;
  end

  task automatic push(input int e, input logic [3:0] r, input logic rd, input logic bz,
                      input logic te, input logic [1:0] ed);
    ev_t ev;
    ev.edge_no = e;
    ev.rstn    = r;
    ev.ready   = rd;
    ev.busy    = bz;
    ev.terr    = te;
    ev.edom    = ed;
    exp_q.push_back(ev);
  endtask

  // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) step();
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.soft_rst_req = 1'b0;
    bus.init_done    = 4'b0000;
    repeat (3) step();
    n_checks += 5;
    if (bus.domain_rstn !== 4'b0000) begin
      n_fail++; $display("FAIL reset_rstn got %b want 0000", bus.domain_rstn);
    end
    if (bus.all_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got %b want 0", bus.all_ready);
    end
    if (bus.seq_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_busy got %b want 1", bus.seq_busy);
    end
    if (bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_terr got %b want 0", bus.timeout_err);
    end
    if (bus.err_domain !== 2'd0) begin
      n_fail++; $display("FAIL reset_edom got %0d want 0", bus.err_domain);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_nominal();
    int b;
    b = edge_cnt;
    push(b + 9,  4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 21, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 33, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 45, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 48, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_until(b + 11 + 12 * k);
      bus.init_done[k] = 1'b1;
    end
    wait_until(b + 55);
    n_checks += 2;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL nominal_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    if (bus.all_ready !== 1'b1 || bus.seq_busy !== 1'b0) begin
      n_fail++; $display("FAIL nominal_ready got ready=%b busy=%b want 1/0",
                         bus.all_ready, bus.seq_busy);
    end
    bus.init_done = 4'b0000;
    wait_until(b + 65);
    n_checks++;
    if (bus.domain_rstn !== 4'b1111 || bus.all_ready !== 1'b1) begin
      n_fail++; $display("FAIL done_hold got rstn=%b ready=%b want 1111/1",
                         bus.domain_rstn, bus.all_ready);
    end
  endtask

  task automatic test_timeout();
    int b;
    b = edge_cnt;
    rst = 1'b1;
    push(b + 1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    rst = 1'b0;
    b = edge_cnt;
    push(b + 9,   4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 21,  4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 33,  4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 289, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2);
    wait_until(b + 11);
    bus.init_done[0] = 1'b1;
    wait_until(b + 23);
    bus.init_done[1] = 1'b1;
    wait_until(b + 35);
    bus.init_done[3] = 1'b1;  // not the domain being waited on
    wait_until(b + 330);
    n_checks += 2;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL timeout_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    if (bus.timeout_err !== 1'b1 || bus.err_domain !== 2'd2 || bus.domain_rstn !== 4'b0000) begin
      n_fail++; $display("FAIL timeout_hold got terr=%b edom=%0d rstn=%b want 1/2/0000",
                         bus.timeout_err, bus.err_domain, bus.domain_rstn);
    end
  endtask

  task automatic test_recovery();
    int s;
    bus.init_done    = 4'b0000;
    bus.soft_rst_req = 1'b1;
    s = edge_cnt + 1;
    push(s,      4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    push(s + 9,  4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    push(s + 20, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    bus.soft_rst_req = 1'b0;
    n_checks++;
    if (bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL recovery_terr got %b want 0", bus.timeout_err);
    end
    wait_until(s + 10);
    bus.init_done[0] = 1'b1;
    wait_until(s + 21);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL recovery_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_priority();
    int p;
    p = edge_cnt + 1;
    bus.soft_rst_req = 1'b1;
    bus.init_done[1] = 1'b1;
    push(p,      4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    push(p + 11, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    n_checks++;
    if (bus.domain_rstn[1] !== 1'b0) begin
      n_fail++; $display("FAIL priority_rstn1 got %b want 0", bus.domain_rstn[1]);
    end
    step();
    step();
    n_checks++;
    if (bus.seq_busy !== 1'b1 || bus.domain_rstn !== 4'b0000) begin
      n_fail++; $display("FAIL soft_held got busy=%b rstn=%b want 1/0000",
                         bus.seq_busy, bus.domain_rstn);
    end
    bus.soft_rst_req = 1'b0;
    bus.init_done    = 4'b0000;
    wait_until(p + 12);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL priority_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_mid_reset();
    int b;
    b = edge_cnt;
    bus.init_done[0] = 1'b1;
    push(b + 10, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_until(b + 12);
    rst = 1'b1;
    push(b + 13, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    rst           = 1'b0;
    bus.init_done = 4'b0000;
    b = edge_cnt;
    push(b + 9, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    wait_until(b + 12);
    n_checks += 2;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL midreset_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    if (bus.domain_rstn !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_rstn got %b want 0001", bus.domain_rstn);
    end
  endtask

  task automatic test_early_ack();
    int b;
    b = edge_cnt;
    rst           = 1'b1;
    bus.init_done = 4'b1111;
    push(b + 1, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0);
    step();
    rst = 1'b0;
    b = edge_cnt;
    push(b + 9,  4'b0001, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 19, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 29, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 39, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
    push(b + 40, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0);
    wait_until(b + 50);
    n_checks += 2;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL early_pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    if (bus.all_ready !== 1'b1) begin
      n_fail++; $display("FAIL early_ready got %b want 1", bus.all_ready);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout();
    test_recovery();
    test_priority();
    test_mid_reset();
    test_early_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
RESET_RELEASE_SEQUENCER -- requirements
Module: reset_release_sequencer

Interface
REQ-001 SHALL have parameter DOMAIN_NUM, default 4: number of downstream reset domains (layer decoder sub-blocks).
REQ-002 SHALL have parameter GAP_CYCLES, default 8: settling cycles before each domain release (valid range 1..255).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 256: maximum cycles to wait for a domain's init_done (valid range 2..65535).
REQ-004 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 soft_rst_req  input  1  restart request, sampled each cycle, level or pulse.
REQ-007 init_done  input  DOMAIN_NUM  per-domain "initialisation complete" status.
REQ-008 domain_rstn  output  DOMAIN_NUM  per-domain active-low reset, registered.
REQ-009 all_ready  output  1  all domains released and acknowledged, registered.
REQ-010 seq_busy  output  1  sequence in progress, registered.
REQ-011 timeout_err  output  1  sticky acknowledge-timeout flag, registered.
REQ-012 err_domain  output  clog2(DOMAIN_NUM), min 1  index of the timed-out domain, registered.

Function
REQ-013 SHALL implement FSM states HOLD, RELEASE, WAIT_ACK, DONE, ERROR.
REQ-014 HOLD: domain_rstn bits at index >= k SHALL be 0; a gap counter counts GAP_CYCLES edges, then the FSM enters RELEASE.
REQ-015 RELEASE: one cycle; domain_rstn[k] SHALL be set to 1 on that edge, the timeout counter cleared, then the FSM enters WAIT_ACK.
REQ-016 Domain 0 release: domain_rstn[0] SHALL rise on the (GAP_CYCLES+1)th rising edge after the first edge with rst=0; GAP_CYCLES=8 gives edge 9.
REQ-017 WAIT_ACK: only init_done[k] is monitored; other init_done bits are ignored.
REQ-018 WAIT_ACK, init_done[k]=1 with k<DOMAIN_NUM-1: k SHALL increment, then HOLD.
REQ-019 WAIT_ACK, init_done[k]=1 with k=DOMAIN_NUM-1: the FSM enters DONE; all_ready=1 and seq_busy=0 on that same edge.
REQ-020 init_done[k] already 1 on the first WAIT_ACK cycle SHALL be accepted immediately.
REQ-021 Timeout: the counter increments each WAIT_ACK cycle; if init_done[k] is still 0 when the count reaches ACK_TIMEOUT, the FSM enters ERROR.
REQ-022 ERROR entry: all domain_rstn SHALL be 0, timeout_err=1, err_domain=k, seq_busy=0, all_ready=0.
REQ-023 ERROR SHALL hold until soft_rst_req or rst.
REQ-024 DONE SHALL hold with all domain_rstn=1; later deassertion of init_done SHALL be ignored.
REQ-025 soft_rst_req=1 in any state SHALL, on that edge, zero all domain_rstn, all_ready, and timeout_err, set err_domain=0, k=0, seq_busy=1, clear counters, and enter HOLD.
REQ-026 soft_rst_req SHALL take priority over init_done and timeout in the same cycle.
REQ-027 soft_rst_req held high SHALL keep the FSM restarting HOLD with counters cleared; the sequence begins on the first cycle it is low.
REQ-028 seq_busy SHALL be 1 in HOLD, RELEASE, and WAIT_ACK.
REQ-029 domain_rstn SHALL be monotonic within one sequence: a released domain never reasserts except via ERROR, soft_rst_req, or rst.
REQ-030 Counters SHALL be sized to hold their maximum values and SHALL never wrap.

Reset
REQ-031 rst=1 SHALL set, on the next edge: state=HOLD, k=0, counters=0, domain_rstn=0, all_ready=0, seq_busy=1, timeout_err=0, err_domain=0.
REQ-032 rst SHALL override soft_rst_req and all other inputs, including when asserted mid-sequence or in DONE or ERROR.

Verification
REQ-033 Nominal release: defaults, each init_done[k] raised 3 cycles after domain_rstn[k] rises -> domain_rstn[0] rises at edge 9 after rst release; each later domain rises 9 edges after the previous ack; all_ready=1 on the ack edge of domain 3.
REQ-034 Timeout: init_done[2] held 0 -> 256 WAIT_ACK cycles after domain_rstn[2] rises, all domain_rstn=0, timeout_err=1, err_domain=2; state holds indefinitely.
REQ-035 Recovery: soft_rst_req pulsed in ERROR -> timeout_err=0 next edge; domain_rstn[0] rises 9 edges after the pulse.
REQ-036 Priority: soft_rst_req and init_done[1] both high in the same WAIT_ACK cycle -> restart; domain_rstn[1] stays 0.
REQ-037 Early ack: init_done=4'b1111 constant from reset -> domains released at edges 9, 19, 29, 39; all_ready=1 at edge 40.
REQ-038 Mid-sequence reset: rst asserted for 1 cycle in WAIT_ACK of domain 1 -> all domain_rstn=0 next edge; the sequence restarts from domain 0.
